// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quad_pkg
// Description : Shared types and constants for the quadcopter motor path.
// Revision    : 1.0 - initial release
// ============================================================================
package quad_pkg;

    localparam int unsigned c_SPD_W  = 11;
    localparam int unsigned c_AXIS_W = 13;
    localparam int unsigned c_MIX_W  = 15;

    localparam logic [c_SPD_W-1:0] c_MIN_RUN_SPEED = 11'h2C0;
    localparam logic [c_SPD_W-1:0] c_CAL_SPEED     = 11'h290;
    localparam logic [c_SPD_W-1:0] c_RAMP_STEP     = 11'h010;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SPINUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_CAL    = 2'd3
    } state_t;

    // pterm + dterm, both sign-extended to 13 bits; cannot overflow.
    function automatic logic [c_AXIS_W-1:0] axis_sum(input logic [9:0]  pterm,
                                                     input logic [11:0] dterm);
        axis_sum = {{3{pterm[9]}}, pterm} + {dterm[11], dterm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spd_sat.sv
`default_nettype none
// ============================================================================
// Module      : spd_sat
// Description : Clamp a 15-bit signed mix value to an 11-bit unsigned speed.
// Revision    : 1.0 - initial release
// ============================================================================
module spd_sat
    import quad_pkg::*;
(
    input  logic [c_MIX_W-1:0] i_mix,
    output logic [c_SPD_W-1:0] o_spd
);

    always_comb begin
        if (i_mix[c_MIX_W-1]) begin
            o_spd = '0;
        end else if (|i_mix[c_MIX_W-2:c_SPD_W]) begin
            o_spd = '1;
        end else begin
            o_spd = i_mix[c_SPD_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/motor_mixer.sv
`default_nettype none
// ============================================================================
// Module      : motor_mixer
// Description : PD terms + thrust to four motor speeds, with spin-up, inertial
//               calibration override and kill handling.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_mixer
    import quad_pkg::*;
#(
    parameter logic [c_SPD_W-1:0] MIN_RUN_SPEED = c_MIN_RUN_SPEED,
    parameter logic [c_SPD_W-1:0] CAL_SPEED     = c_CAL_SPEED,
    parameter logic [c_SPD_W-1:0] RAMP_STEP     = c_RAMP_STEP
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic               go,
    input  logic               inertial_cal,
    input  logic [8:0]         thrst,
    input  logic [9:0]         ptch_pterm,
    input  logic [9:0]         roll_pterm,
    input  logic [9:0]         yaw_pterm,
    input  logic [11:0]        ptch_dterm,
    input  logic [11:0]        roll_dterm,
    input  logic [11:0]        yaw_dterm,
    output logic [c_SPD_W-1:0] frnt_spd,
    output logic [c_SPD_W-1:0] bck_spd,
    output logic [c_SPD_W-1:0] lft_spd,
    output logic [c_SPD_W-1:0] rght_spd,
    output logic               spd_vld
);

    state_t                      r_state, w_state_nxt;
    logic [3:0][c_SPD_W-1:0]     r_spd, w_spd_nxt, w_sat;
    logic                        r_spd_vld, w_spd_vld_nxt;
    logic                        r_v1, r_v2;
    logic                        w_run_acc, w_squash;
    logic [c_AXIS_W-1:0]         r_ptch, r_roll, r_yaw;
    logic [8:0]                  r_thrst;
    logic [3:0][c_MIX_W-1:0]     r_mix;
    logic [c_MIX_W-1:0]          w_base, w_ptch, w_roll, w_yaw;
    logic [c_SPD_W:0]            w_ramp_sum;
    logic [c_SPD_W-1:0]          w_ramp;

    // Kill or calibration both empty the mixer pipeline.
    assign w_squash = !go || inertial_cal;

    assign w_base = {{(c_MIX_W-9){1'b0}}, r_thrst} + {{(c_MIX_W-c_SPD_W){1'b0}}, MIN_RUN_SPEED};
    assign w_ptch = {{(c_MIX_W-c_AXIS_W){r_ptch[c_AXIS_W-1]}}, r_ptch};
    assign w_roll = {{(c_MIX_W-c_AXIS_W){r_roll[c_AXIS_W-1]}}, r_roll};
    assign w_yaw  = {{(c_MIX_W-c_AXIS_W){r_yaw[c_AXIS_W-1]}}, r_yaw};

    assign w_ramp_sum = {1'b0, r_spd[0]} + {1'b0, RAMP_STEP};
    assign w_ramp     = (w_ramp_sum > {1'b0, MIN_RUN_SPEED}) ? MIN_RUN_SPEED
                                                             : w_ramp_sum[c_SPD_W-1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sat
            spd_sat u_sat (
                .i_mix (r_mix[gi]),
                .o_spd (w_sat[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_spd_nxt     = r_spd;
        w_spd_vld_nxt = 1'b0;
        w_run_acc     = 1'b0;
        if (!go) begin
            // One zeroed pulse on kill, then zeros echoed on every vld.
            w_state_nxt   = ST_OFF;
            w_spd_nxt     = '0;
            w_spd_vld_nxt = vld || (r_state != ST_OFF);
        end else if (inertial_cal) begin
            w_state_nxt = ST_CAL;
            if (vld) begin
                w_spd_nxt     = {4{CAL_SPEED}};
                w_spd_vld_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (vld) begin
                        w_state_nxt   = ST_SPINUP;
                        w_spd_nxt     = {4{RAMP_STEP}};
                        w_spd_vld_nxt = 1'b1;
                    end
                end
                ST_SPINUP: begin
                    if (vld) begin
                        w_spd_nxt     = {4{w_ramp}};
                        w_spd_vld_nxt = 1'b1;
                        if (w_ramp == MIN_RUN_SPEED) begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    w_run_acc = vld;
                    if (r_v2) begin
                        w_spd_nxt     = w_sat;
                        w_spd_vld_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_OFF;
            r_spd     <= '0;
            r_spd_vld <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_ptch    <= '0;
            r_roll    <= '0;
            r_yaw     <= '0;
            r_thrst   <= '0;
            r_mix     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_spd     <= w_spd_nxt;
            r_spd_vld <= w_spd_vld_nxt;
            r_v1      <= w_run_acc;
            r_v2      <= r_v1 && !w_squash;
            if (w_run_acc) begin
                r_ptch  <= axis_sum(ptch_pterm, ptch_dterm);
                r_roll  <= axis_sum(roll_pterm, roll_dterm);
                r_yaw   <= axis_sum(yaw_pterm, yaw_dterm);
                r_thrst <= thrst;
            end
            if (r_v1) begin
                r_mix[0] <= w_base + w_ptch - w_yaw;
                r_mix[1] <= w_base - w_ptch - w_yaw;
                r_mix[2] <= w_base - w_roll + w_yaw;
                r_mix[3] <= w_base + w_roll + w_yaw;
            end
        end
    end

    assign frnt_spd = r_spd[0];
    assign bck_spd  = r_spd[1];
    assign lft_spd  = r_spd[2];
    assign rght_spd = r_spd[3];
    assign spd_vld  = r_spd_vld;

endmodule
`default_nettype wire

// File: tb/tb_motor_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_mixer
// Description : Directed self-checking bench for motor_mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_mixer;

    logic        clk = 1'b0;
    logic        rst_n, vld, go, inertial_cal;
    logic [8:0]  thrst;
    logic [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
    logic [11:0] ptch_dterm, roll_dterm, yaw_dterm;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic        spd_vld;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motor_mixer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld          (vld),
        .go           (go),
        .inertial_cal (inertial_cal),
        .thrst        (thrst),
        .ptch_pterm   (ptch_pterm),
        .roll_pterm   (roll_pterm),
        .yaw_pterm    (yaw_pterm),
        .ptch_dterm   (ptch_dterm),
        .roll_dterm   (roll_dterm),
        .yaw_dterm    (yaw_dterm),
        .frnt_spd     (frnt_spd),
        .bck_spd      (bck_spd),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .spd_vld      (spd_vld)
    );

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_spd(input string tag, input logic [10:0] f, input logic [10:0] b,
                             input logic [10:0] l, input logic [10:0] r, input logic v);
        check({tag, ".frnt"}, frnt_spd, f);
        check({tag, ".bck"},  bck_spd,  b);
        check({tag, ".lft"},  lft_spd,  l);
        check({tag, ".rght"}, rght_spd, r);
        check({tag, ".vld"},  11'(spd_vld), 11'(v));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic set_axes(input logic [8:0] t, input logic [9:0] pp, input logic [11:0] pd,
                            input logic [9:0] rp, input logic [11:0] rd,
                            input logic [9:0] yp, input logic [11:0] yd);
        thrst = t;
        ptch_pterm = pp; ptch_dterm = pd;
        roll_pterm = rp; roll_dterm = rd;
        yaw_pterm  = yp; yaw_dterm  = yd;
    endtask

    // Single RUN vld; returns on the cycle the result should be visible.
    task automatic run_vec(input string tag);
        pulse();
        check({tag, ".lat1"}, 11'(spd_vld), 11'd0);
        tick();
        check({tag, ".lat2"}, 11'(spd_vld), 11'd0);
        tick();
    endtask

    task automatic spin_up(input string tag);
        for (int i = 0; i < 44; i++) begin
            pulse();
            check($sformatf("%s.ramp%0d", tag, i), frnt_spd, 11'((i + 1) * 16));
            check($sformatf("%s.rvld%0d", tag, i), 11'(spd_vld), 11'd1);
            tick();
        end
        check_spd({tag, ".done"}, 11'h2C0, 11'h2C0, 11'h2C0, 11'h2C0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; go = 1'b0; inertial_cal = 1'b0;
        set_axes(9'd0, 10'd0, 12'd0, 10'd0, 12'd0, 10'd0, 12'd0);
        repeat (3) tick();
        check_spd("reset", 11'h0, 11'h0, 11'h0, 11'h0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Kill state: zeros echoed one cycle after each vld
        for (int i = 0; i < 3; i++) begin
            pulse();
            check_spd("off_pulse", 11'h0, 11'h0, 11'h0, 11'h0, 1'b1);
            tick();
            check("off_idle", 11'(spd_vld), 11'd0);
        end

        go = 1'b1;
        spin_up("spin1");

        set_axes(9'h100, 10'd20, 12'd30, 10'd0, 12'd0, 10'd0, 12'd0);
        run_vec("mix_ptch");
        check_spd("mix_ptch", 11'h3F2, 11'h38E, 11'h3C0, 11'h3C0, 1'b1);
        tick();
        check("mix_ptch.end", 11'(spd_vld), 11'd0);

        set_axes(9'h1FF, 10'd0, 12'h7FF, 10'd0, 12'h7FF, 10'd0, 12'h7FF);
        run_vec("sat_hi");
        check_spd("sat_hi", 11'h4BF, 11'h000, 11'h4BF, 11'h7FF, 1'b1);

        set_axes(9'h1FF, 10'd0, 12'h800, 10'd0, 12'h800, 10'd0, 12'h800);
        run_vec("sat_lo");
        check_spd("sat_lo", 11'h4BF, 11'h7FF, 11'h4BF, 11'h000, 1'b1);

        // Back-to-back vld, results in order
        set_axes(9'h000, 10'd0, 12'd0, 10'd0, 12'd0, 10'd0, 12'd0);
        vld = 1'b1;
        tick();
        thrst = 9'h010;
        tick();
        thrst = 9'h020;
        tick();
        check_spd("b2b_a", 11'h2C0, 11'h2C0, 11'h2C0, 11'h2C0, 1'b1);
        vld = 1'b0;
        tick();
        check_spd("b2b_b", 11'h2D0, 11'h2D0, 11'h2D0, 11'h2D0, 1'b1);
        tick();
        check_spd("b2b_c", 11'h2E0, 11'h2E0, 11'h2E0, 11'h2E0, 1'b1);
        tick();
        check("b2b_end", 11'(spd_vld), 11'd0);

        // Kill with results still in flight
        thrst = 9'h030;
        vld = 1'b1;
        tick();
        thrst = 9'h040;
        tick();
        thrst = 9'h050;
        tick();
        check_spd("kill_a", 11'h2F0, 11'h2F0, 11'h2F0, 11'h2F0, 1'b1);
        vld = 1'b0;
        go  = 1'b0;
        tick();
        check_spd("kill", 11'h0, 11'h0, 11'h0, 11'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_spd($sformatf("kill_after%0d", i), 11'h0, 11'h0, 11'h0, 11'h0, 1'b0);
        end

        go = 1'b1;
        spin_up("spin2");
        inertial_cal = 1'b1;
        tick();
        check_spd("cal_enter", 11'h2C0, 11'h2C0, 11'h2C0, 11'h2C0, 1'b0);
        pulse();
        check_spd("cal", 11'h290, 11'h290, 11'h290, 11'h290, 1'b1);
        tick();
        check("cal_idle", 11'(spd_vld), 11'd0);
        inertial_cal = 1'b0;
        tick();
        pulse();
        check_spd("respin", 11'h010, 11'h010, 11'h010, 11'h010, 1'b1);
        tick();

        // go=0 outranks inertial_cal
        go = 1'b0;
        inertial_cal = 1'b1;
        pulse();
        check_spd("kill_cal", 11'h0, 11'h0, 11'h0, 11'h0, 1'b1);
        tick();
        inertial_cal = 1'b0;

        // Asynchronous reset mid-operation
        go = 1'b1;
        pulse();
        tick();
        pulse();
        check("pre_rst", frnt_spd, 11'h020);
        rst_n = 1'b0;
        #1;
        check_spd("async_rst", 11'h0, 11'h0, 11'h0, 11'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse();
        check_spd("post_rst", 11'h010, 11'h010, 11'h010, 11'h010, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
